// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: N valid/ready input channels,
// one registered valid/ready output, plus the arbitration controls.
interface mux_arb_reg_if #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4
) ();
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode,
        output sel,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  mode,
        input  sel,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/mux_arb_reg.sv
// N-channel registered mux with manual select or round-robin arbitration.
// One word per cycle; the output register refills in the cycle it drains.
module mux_arb_reg #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4
) (
    input logic          clk,
    input logic          rst_n,
    mux_arb_reg_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef logic [SEL_W-1:0] ch_t;
    typedef logic [SEL_W:0]   ch_ext_t;

    localparam ch_t     LAST_CH = ch_t'(CHANNELS - 1);
    localparam ch_ext_t CH_N    = ch_ext_t'(CHANNELS);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    ch_t              out_ch_q, out_ch_d;
    ch_t              ptr_q, ptr_d;

    logic                load;
    logic                man_hit;
    ch_t                 man_ch;
    logic                rr_hit;
    ch_t                 rr_ch;
    logic                gnt;
    ch_t                 gnt_ch;
    logic [WIDTH-1:0]    gnt_data;
    logic [CHANNELS-1:0] rdy;

    assign load = !out_valid_q || bus.out_ready;

    // Manual select: indices at or above CHANNELS never match a channel.
    always_comb begin
        man_hit = 1'b0;
        man_ch  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.sel == ch_t'(c) && bus.in_valid[c]) begin
                man_hit = 1'b1;
                man_ch  = ch_t'(c);
            end
        end
    end

    // Rotate valids so bit 0 is ptr+1, take the first set bit, map it back.
    logic [2*CHANNELS-1:0] vld_dbl;
    logic [2*CHANNELS-1:0] vld_shr;
    logic [CHANNELS-1:0]   vld_rot;
    ch_ext_t               rr_start;
    ch_ext_t               rr_sum;
    ch_ext_t               rr_wrap;
    ch_t                   rr_off;

    always_comb begin
        vld_dbl  = {bus.in_valid, bus.in_valid};
        rr_start = {1'b0, ptr_q} + 1'b1;
        vld_shr  = vld_dbl >> rr_start;
        vld_rot  = vld_shr[CHANNELS-1:0];
        rr_hit   = 1'b0;
        rr_off   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!rr_hit && vld_rot[k]) begin
                rr_hit = 1'b1;
                rr_off = ch_t'(k);
            end
        end
        rr_sum  = rr_start + {1'b0, rr_off};
        rr_wrap = (rr_sum >= CH_N) ? (rr_sum - CH_N) : rr_sum;
        rr_ch   = rr_wrap[SEL_W-1:0];
    end

    // No grant while in reset so in_ready stays low.
    always_comb begin
        gnt    = 1'b0;
        gnt_ch = '0;
        if (rst_n && load) begin
            if (bus.mode) begin
                gnt    = rr_hit;
                gnt_ch = rr_ch;
            end else begin
                gnt    = man_hit;
                gnt_ch = man_ch;
            end
        end
    end

    always_comb begin
        rdy      = '0;
        gnt_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (gnt && gnt_ch == ch_t'(c)) begin
                rdy[c]   = 1'b1;
                gnt_data = bus.in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (gnt) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_ch;
            ptr_d       = gnt_ch;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= LAST_CH;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb_reg.sv
// Randomized scoreboard bench for mux_arb_reg, run on a 4x2 and a
// non-power-of-two 3x4 configuration side by side.
module tb_mux_arb_reg;
    localparam int NCYC  = 2500;
    localparam int LIMIT = NCYC + 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    task automatic chk(input int g, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0h want %0h at %0t",
                     g, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int CH = (g == 0) ? 4 : 3;
        localparam int W  = (g == 0) ? 2 : 4;
        localparam int SW = $clog2(CH);

        logic rst_n;
        mux_arb_reg_if #(.WIDTH(W), .CHANNELS(CH)) ifc ();

        mux_arb_reg #(.WIDTH(W), .CHANNELS(CH)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (ifc)
        );

        logic [W-1:0] q_d[$];
        int           q_c[$];

        // Reference: "last served" channel and an occupancy flag.
        int            last;
        bit            occ;
        bit            was_rst;
        bit            g_ok;
        int            g_ch;
        logic [W-1:0]  g_data;
        logic [CH-1:0] exp_rdy;

        initial begin
            rst_n         = 1'b0;
            ifc.mode      = 1'b1;
            ifc.sel       = '0;
            ifc.in_valid  = '1;
            ifc.in_data   = '0;
            ifc.out_ready = 1'b1;
            last          = CH - 1;
            occ           = 1'b0;
            g_ok          = 1'b0;
            g_ch          = 0;
            g_data        = '0;
            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(posedge clk);
                was_rst = !rst_n;
                if (!rst_n) begin
                    occ  = 1'b0;
                    last = CH - 1;
                    q_d.delete();
                    q_c.delete();
                end else if (g_ok) begin
                    q_d.push_back(g_data);
                    q_c.push_back(g_ch);
                    occ  = 1'b1;
                    last = g_ch;
                end else if (ifc.out_ready) begin
                    occ = 1'b0;
                end
                #1;
                rst_n = (cyc >= 2) && ($urandom_range(99) >= 2);
                if ($urandom_range(19) == 0) ifc.mode = ~ifc.mode;
                ifc.sel = SW'($urandom_range((1 << SW) - 1));
                if ($urandom_range(3) == 0) ifc.in_valid = '1;
                else ifc.in_valid = CH'($urandom);
                for (int c = 0; c < CH; c++)
                    ifc.in_data[c*W +: W] = W'($urandom);
                ifc.out_ready = ($urandom_range(9) < 7);

                g_ok = 1'b0;
                g_ch = 0;
                if (rst_n && (!occ || ifc.out_ready)) begin
                    if (!ifc.mode) begin
                        int s;
                        s = int'(ifc.sel);
                        if (s < CH && ifc.in_valid[s]) begin
                            g_ok = 1'b1;
                            g_ch = s;
                        end
                    end else begin
                        for (int k = 1; k <= CH; k++) begin
                            int c;
                            c = (last + k) % CH;
                            if (!g_ok && ifc.in_valid[c]) begin
                                g_ok = 1'b1;
                                g_ch = c;
                            end
                        end
                    end
                end
                g_data  = ifc.in_data[g_ch*W +: W];
                exp_rdy = '0;
                if (g_ok) exp_rdy[g_ch] = 1'b1;

                #1;
                chk(g, "in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
                chk(g, "out_valid", 32'(ifc.out_valid), 32'(occ));
                if (was_rst) begin
                    chk(g, "rst_out_data", 32'(ifc.out_data), 0);
                    chk(g, "rst_out_ch", 32'(ifc.out_ch), 0);
                end
            end
            done_cnt++;
        end

        initial begin
            logic [W-1:0] ed;
            int           ec;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && ifc.out_valid === 1'b1 &&
                    ifc.out_ready === 1'b1) begin
                    chk(g, "word_pending", 32'(q_d.size() > 0), 1);
                    if (q_d.size() > 0) begin
                        ed = q_d.pop_front();
                        ec = q_c.pop_front();
                        chk(g, "out_data", 32'(ifc.out_data), 32'(ed));
                        chk(g, "out_ch", 32'(ifc.out_ch), 32'(ec));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < LIMIT && done_cnt < 2; i++) @(posedge clk);
        if (done_cnt < 2) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got %0d done want 2", done_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-channel registered multiplexer with a valid/ready handshake on every input channel and on the output.
- Successor to the fixed 4:1 combinational switch mux: channel count and width are generics, the output is registered, and a mode input selects manual (sel-driven) or round-robin arbitration.
- Sits between switch/peripheral sources and a single downstream consumer (display driver, UART TX) on the board clock.

Parameters:
- WIDTH, 2, data bits per channel.
- CHANNELS, 4, number of input channels (2..16, need not be a power of 2).
- SEL_W, $clog2(CHANNELS) (min 1), width of sel and out_ch; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- mode  input  1  0 = manual select, 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used in mode 0.
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data-valid.
- in_ready  output  CHANNELS  per-channel accept; at most one bit high.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that out_data came from.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
  - in_ready is all-zero while rst_n=0.
- Reset mid-transfer discards the held word; no in_ready pulse in that cycle.
- load = !out_valid || out_ready (output register empty or draining this cycle).
- Grant (combinational, same cycle):
  - mode 0: candidate = sel. Grant iff load && sel<CHANNELS && in_valid[sel]. sel>=CHANNELS never grants.
  - mode 1: candidate = first c with in_valid[c]=1, searching ptr+1, ptr+2, … modulo CHANNELS (wrap CHANNELS-1 -> 0). Grant iff load && any in_valid.
  - in_ready[c]=1 only for the granted c. An input transfer occurs when in_valid[c] && in_ready[c].
- On a grant edge:
  - out_data <= in_data[c]; out_ch <= c; out_valid <= 1; ptr <= c.
  - ptr updates in both modes, so switching to mode 1 continues after the last channel served.
- No grant && out_ready: out_valid <= 0. Otherwise out_valid and out_data hold.
- Latency: input transfer at edge N -> out_valid=1 with that data after edge N. Throughput: one word per cycle while out_ready=1.
- Back-pressure: out_valid=1 && out_ready=0 -> in_ready all-zero; out_data/out_ch stable until accepted.
- Simultaneous out_ready=1 and new grant: old word consumed and new word loaded at the same edge; no bubble.
- A mode or sel change takes effect on the next grant decision; a held output word is unaffected.
- in_data of non-granted channels is ignored. No combinational path from in_data to out_data.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0; first RR grant after release goes to channel 0.
- Manual mode: mode=0, sel=2, in_data ch2=2'b11, in_valid=0100, out_ready=1 -> in_ready=0100; next cycle out_data=3, out_ch=2, out_valid=1. sel=3 with in_valid[3]=0 -> no grant, out_valid drops to 0.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1, ch c data=c -> out_ch sequence 0,1,2,3,0, one per cycle. With in_valid=1010 -> sequence 1,3,1,3.
- Back-pressure: out_valid=1, out_ch=1, out_ready=0 for 3 cycles -> in_ready=0000, out_data/out_ch constant. out_ready=1 -> next word (ch 3 when in_valid=1010) loaded the same edge with no gap.
- Non-power-of-2: CHANNELS=3, WIDTH=4, mode=1, in_valid=111 -> out_ch 0,1,2,0 (wrap at 2). mode=0 with sel=3 -> in_ready=000, out_valid stays 0.
- Mid-operation reset and mode switch: after RR grants 0,1, switch to mode=0 with sel=3 -> grant ch3. Switch back to mode=1 -> next grant ch0 (ptr=3). Assert rst_n=0 while out_valid=1 -> out_valid=0 next cycle.
